fifo_byte_drain: RTL
====================

FIFO_BYTE_DRAIN -- requirements
Module: fifo_byte_drain

Interface
REQ-001 Parameter PKT_LEN, default 16, bytes per output packet; m_last marks the final byte; legal range 2..65535.
REQ-002 Parameter BUF_DEPTH, default 4, output buffer entries; power of two, minimum 4.
REQ-003 clk  input  1  single clock for all logic; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_enable  input  1  drain enable; level-sensitive.
REQ-006 i_fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 i_fifo_rdata  input  8  upstream FIFO read byte; valid exactly one cycle after an accepted read.
REQ-008 o_fifo_rden  output  1  read strobe to the upstream FIFO.
REQ-009 o_m_valid  output  1  output byte valid.
REQ-010 i_m_ready  input  1  downstream ready.
REQ-011 o_m_data  output  8  output byte.
REQ-012 o_m_last  output  1  last byte of the packet; qualified by o_m_valid.
REQ-013 o_byte_cnt  output  16  total bytes transferred downstream; wraps modulo 2^16.
REQ-014 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 A downstream transfer SHALL occur on a cycle where o_m_valid && i_m_ready.
REQ-016 Once o_m_valid is high, o_m_valid, o_m_data and o_m_last SHALL hold stable until transfer.
REQ-017 A read is accepted on a cycle where o_fifo_rden && !i_fifo_empty; o_fifo_rden SHALL never assert while i_fifo_empty is high.
REQ-018 The byte from an accepted read in cycle N SHALL be captured from i_fifo_rdata at the end of cycle N+1 into the buffer tail.
REQ-019 o_fifo_rden SHALL equal (state==RUN) && !i_fifo_empty && (occupancy + in_flight) < BUF_DEPTH; in_flight is 0 or 1; a same-cycle pop gives no credit.
REQ-020 The buffer SHALL be FIFO-ordered: bytes leave in read-acceptance order with no loss or duplication; o_m_valid = (occupancy != 0); o_m_data = head entry.
REQ-021 Simultaneous capture and transfer SHALL leave occupancy unchanged; occupancy SHALL never exceed BUF_DEPTH.
REQ-022 With i_m_ready held high and FIFO non-empty, steady-state throughput SHALL be one byte per cycle.
REQ-023 A packet counter (0..PKT_LEN-1) SHALL increment on each transfer and wrap to 0 after PKT_LEN-1; o_m_last = o_m_valid && (counter == PKT_LEN-1).
REQ-024 The packet counter SHALL persist across enable toggles; packets are never truncated by i_enable.
REQ-025 o_byte_cnt SHALL increment by 1 per transfer, wrapping 0xFFFF -> 0x0000.
REQ-026 States: IDLE, RUN, DRAIN.
REQ-027 IDLE -> RUN when i_enable is high.
REQ-028 RUN -> DRAIN when i_enable is low.
REQ-029 DRAIN -> RUN when i_enable is high again.
REQ-030 DRAIN -> IDLE when occupancy == 0, in_flight == 0 and no capture is pending.
REQ-031 In DRAIN, no new reads SHALL be issued; an in-flight byte SHALL still be captured and delivered.

Reset
REQ-032 While reset is low: state=IDLE, occupancy=0, in_flight=0, packet counter=0, o_byte_cnt=0, o_fifo_rden=0, o_m_valid=0, o_m_last=0, o_busy=0, o_m_data=0x00.
REQ-033 Reset asserted mid-transfer SHALL discard buffered and in-flight bytes immediately; the first read after release SHALL occur no earlier than the first rising edge following release.

Verification
REQ-034 FIFO preloaded 0x00..0x1F, i_enable=1, i_m_ready=1 -> 32 bytes out in order, one per cycle after a 2-cycle initial latency; o_m_last on bytes 0x0F and 0x1F; o_byte_cnt=32.
REQ-035 i_m_ready low for 10 cycles mid-stream -> exactly BUF_DEPTH bytes buffered, o_fifo_rden low, o_m_data held stable; no byte lost on resume.
REQ-036 i_enable dropped in the same cycle as an accepted read -> that byte is delivered, then IDLE with o_busy=0; packet counter resumes correctly on re-enable.
REQ-037 FIFO empties mid-packet after byte 5 -> o_m_valid low after buffer drains; refill continues the packet with o_m_last on the 16th byte overall.
REQ-038 o_byte_cnt forced near wrap (0xFFFE) by 4 transfers -> sequence 0xFFFF, 0x0000, 0x0001, 0x0002.
REQ-039 reset pulsed low with 3 bytes buffered -> all outputs at reset values in the same cycle; no stale bytes emitted after release.

Source files
------------

// File: rtl/fifo_byte_drain_if.sv
// fifo_byte_drain_if: upstream FIFO read port plus downstream valid/ready byte stream.
interface fifo_byte_drain_if;
   logic       i_fifo_empty;
   logic [7:0] i_fifo_rdata;
   logic       o_fifo_rden;
   logic       o_m_valid;
   logic       i_m_ready;
   logic [7:0] o_m_data;
   logic       o_m_last;
   modport slave (
      input  i_fifo_empty, i_fifo_rdata, i_m_ready,
      output o_fifo_rden, o_m_valid, o_m_data, o_m_last
   );
   modport master (
      output i_fifo_empty, i_fifo_rdata, i_m_ready,
      input  o_fifo_rden, o_m_valid, o_m_data, o_m_last
   );
endinterface

// File: rtl/fifo_byte_drain.sv
// fifo_byte_drain: drains an upstream FIFO into a small buffer and emits fixed-length byte packets.
module fifo_byte_drain #(
   parameter int PKT_LEN   = 16,
   parameter int BUF_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_enable,
   fifo_byte_drain_if.slave      bus,
   output logic [15:0]           o_byte_cnt,
   output logic                  o_busy
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);
   localparam logic [15:0] LAST = 16'(PKT_LEN - 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t        state;
   logic [7:0]    mem [BUF_DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0]   occ;
   logic          in_flight;
   logic [15:0]   pkt;
   logic          pop;
   always_comb begin
      // credit counts the in-flight byte; a same-cycle pop frees nothing yet
      bus.o_fifo_rden = state == RUN && !bus.i_fifo_empty && (occ + (AW+1)'(in_flight)) < DEPTH;
      bus.o_m_valid   = occ != '0;
      bus.o_m_data    = bus.o_m_valid ? mem[head] : 8'h00;
      bus.o_m_last    = bus.o_m_valid && pkt == LAST;
      pop             = bus.o_m_valid && bus.i_m_ready;
      o_busy          = state != IDLE;
   end
   always_ff @(posedge clk) if (in_flight) mem[tail] <= bus.i_fifo_rdata;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         head       <= '0;
         tail       <= '0;
         occ        <= '0;
         in_flight  <= 1'b0;
         pkt        <= '0;
         o_byte_cnt <= '0;
      end else begin
         in_flight <= bus.o_fifo_rden;
         occ       <= occ + (AW+1)'(in_flight) - (AW+1)'(pop);
         if (in_flight) tail <= tail + 1'b1;
         if (pop) begin
            head       <= head + 1'b1;
            pkt        <= pkt == LAST ? 16'd0 : pkt + 16'd1;
            o_byte_cnt <= o_byte_cnt + 16'd1;
         end
         state <= state == IDLE ? (i_enable ? RUN : IDLE) :
                  state == RUN  ? (i_enable ? RUN : DRAIN) :
                  i_enable      ? RUN :
                  (occ == '0 && !in_flight) ? IDLE : DRAIN;
      end
   end
endmodule
